// File: rtl/sub32_pipe.sv
// Two-stage pipelined subtractor (diff = A - B - b_in) with valid/ready handshake.
// The low half and its carry are registered in stage 1; the high half completes in stage 2.
module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;

  logic            s1_valid;
  logic [HALF-1:0] lo_diff;
  logic [HALF-1:0] a_hi;
  logic [HALF-1:0] b_hi;
  logic            c_mid;

  logic             out_free;
  logic             s1_free;
  logic             accept;
  logic             advance;
  logic [HALF:0]    lo_sum;
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] full;

  assign out_free = !out_valid || out_ready;
  assign s1_free  = !s1_valid || out_free;
  assign in_ready = s1_free;
  assign accept   = in_valid && s1_free;
  assign advance  = s1_valid && out_free;

  // Subtraction as A + ~B + !b_in: a carry of 1 out of a half means no borrow.
  assign lo_sum = {1'b0, A[HALF-1:0]} + {1'b0, ~B[HALF-1:0]} + {{HALF{1'b0}}, !b_in};
  assign hi_sum = {1'b0, a_hi} + {1'b0, ~b_hi} + {{HALF{1'b0}}, c_mid};
  assign full   = {hi_sum[HALF-1:0], lo_diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      lo_diff  <= '0;
      a_hi     <= '0;
      b_hi     <= '0;
      c_mid    <= 1'b0;
    end else begin
      if (s1_free) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        lo_diff <= lo_sum[HALF-1:0];
        c_mid   <= lo_sum[HALF];
        a_hi    <= A[WIDTH-1:HALF];
        b_hi    <= B[WIDTH-1:HALF];
      end
    end
  end

  // Result and flags only change when a new beat moves in; a drained output keeps its last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (out_free) begin
        out_valid <= s1_valid;
      end
      if (advance) begin
        diff  <= full;
        b_out <= !hi_sum[HALF];
        zero  <= (full == '0);
        neg   <= full[WIDTH-1];
        ovf   <= (a_hi[HALF-1] != b_hi[HALF-1]) && (full[WIDTH-1] != a_hi[HALF-1]);
      end
    end
  end

endmodule

// File: tb/tb_sub32_pipe.sv
// Self-checking bench for sub32_pipe: directed vectors, random-stall stream, throughput and mid-flight reset.
// A FIFO occupancy model checks handshake signals and results on every cycle.
module tb_sub32_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        b_out;
  logic        zero;
  logic        neg;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int pop_count = 0;
  logic [35:0] exp_q[$];
  logic last_acc = 1'b0;

  sub32_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {diff, b_out, zero, neg, ovf} from plain wide unsigned and signed arithmetic.
  function automatic logic [35:0] model(input logic [31:0] av, input logic [31:0] bv, input logic bin);
    logic [32:0] wide;
    longint      s;
    logic        o;
    wide = {1'b0, av} - {1'b0, bv} - {32'd0, bin};
    s    = longint'($signed(av)) - longint'($signed(bv)) - longint'(bin);
    o    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {wide[31:0], wide[32], wide[31:0] == 32'd0, wide[31], o};
  endfunction

  task automatic check_output(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, got, want, $time);
    end
  endtask

  // Occupancy model: in-flight beats live in exp_q; a beat accepted at the latest edge is still in stage 1.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      check_output("out_valid", 36'(out_valid),
                   36'((exp_q.size() == 2) || (exp_q.size() == 1 && !last_acc)));
      check_output("in_ready", 36'(in_ready), 36'(!(exp_q.size() == 2 && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious: out_valid=1 with nothing in flight, diff %h", diff);
        end else begin
          check_output("result", {diff, b_out, zero, neg, ovf}, exp_q[0]);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_count++;
      end
      last_acc = in_valid && in_ready;
      if (last_acc) exp_q.push_back(model(a, b, b_in));
    end
  end

  // One beat into an empty pipe with out_ready high; checks latency and a literal result.
  task automatic apply_stimulus(input string name, input logic [31:0] av, input logic [31:0] bv,
                                input logic bin, input logic [35:0] want);
    @(posedge clk); #1;
    a = av; b = bv; b_in = bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
    @(negedge clk); #1;
    check_output({name, "_lat1"}, 36'(out_valid), 36'd0);
    @(negedge clk); #1;
    check_output({name, "_valid"}, 36'(out_valid), 36'd1);
    check_output(name, {diff, b_out, zero, neg, ovf}, want);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int idx;
    int base;
    int cyc;
    logic hs;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
    #12;
    check_output("reset_outputs", {out_valid, diff, b_out, zero, neg}, 36'd0);
    check_output("reset_ovf", 36'(ovf), 36'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check_output("ready_after_reset", 36'(in_ready), 36'd1);

    apply_stimulus("sub_5_3",    32'd5,          32'd3,          1'b0, {32'h00000002, 4'b0000});
    apply_stimulus("sub_0_1",    32'd0,          32'd1,          1'b0, {32'hFFFFFFFF, 4'b1010});
    apply_stimulus("cross_half", 32'h00010000,   32'd1,          1'b0, {32'h0000FFFF, 4'b0000});
    apply_stimulus("borrow_in",  32'd7,          32'd6,          1'b1, {32'h00000000, 4'b0100});
    apply_stimulus("ovf_neg",    32'h80000000,   32'd1,          1'b0, {32'h7FFFFFFF, 4'b0001});
    apply_stimulus("ovf_pos",    32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, {32'h80000000, 4'b1011});

    // Random stream with random back-pressure; operands stay put until accepted.
    @(posedge clk); #1;
    base = pop_count;
    idx = 0;
    a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    for (cyc = 0; cyc < 400 && !(idx == 8 && exp_q.size() == 0); cyc++) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin
        idx++;
        if (idx < 8) begin
          a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = (idx == 8) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    check_output("stream_accepted", 36'(idx), 36'd8);
    check_output("stream_delivered", 36'(pop_count - base), 36'd8);

    // Back-to-back beats with out_ready high: 8 results in the 8 cycles after the first fill.
    out_ready = 1'b1;
    @(posedge clk); #1;
    base = pop_count;
    a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1)); in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 7) begin
        a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk); #1;
    check_output("throughput", 36'(pop_count - base), 36'd8);
    repeat (2) @(posedge clk);

    // Fill both stages under back-pressure, then reset mid-flight.
    #1 out_ready = 1'b0;
    a = 32'd100; b = 32'd1; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd200; b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    check_output("full_valid", 36'(out_valid), 36'd1);
    check_output("full_ready", 36'(in_ready), 36'd0);
    check_output("full_diff", 36'(diff), 36'd99);
    rst_n = 1'b0;
    #1;
    check_output("async_reset", {out_valid, diff, b_out, zero, neg}, 36'd0);
    check_output("async_reset_ovf", 36'(ovf), 36'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); #1;
    check_output("ready_after_midreset", 36'(in_ready), 36'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check_output("no_stale_result", 36'(out_valid), 36'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
